// File: rtl/frv_irq_arbiter_pkg.sv
// Shared widths, trap-cause prefix and FSM encoding for the platform interrupt arbiter.
// Optional edge-triggered sources are enabled by defining FRV_IRQ_EDGE_EN.
package frv_irq_arbiter_pkg;

  localparam int unsigned IRQ_ID_W = 4;
  localparam logic [1:0] TRAP_INT_EXT_PFX = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_REQ   = 2'd2,
    ST_INSVC = 2'd3
  } arb_state_e;

endpackage

// File: rtl/frv_irq_arbiter_if.sv
// Core-facing side of the interrupt arbiter: raise/cause out, trap ack and completion in.
// Handshake: ex_pending/ex_cause hold until a matching trap ack claims the id; irq_done releases it.
interface frv_irq_arbiter_if;
  import frv_irq_arbiter_pkg::*;

  logic                ex_pending;
  logic [IRQ_ID_W-1:0] ex_cause;
  logic                int_trap_ack;
  logic [5:0]          int_trap_cause;
  logic                irq_done;
  logic [IRQ_ID_W-1:0] irq_done_id;
  logic [IRQ_ID_W-1:0] insvc_id;

  modport master (
    output ex_pending, ex_cause, insvc_id,
    input  int_trap_ack, int_trap_cause, irq_done, irq_done_id
  );

  modport slave (
    input  ex_pending, ex_cause, insvc_id,
    output int_trap_ack, int_trap_cause, irq_done, irq_done_id
  );
endinterface

// File: rtl/frv_irq_arbiter_prio_tree.sv
// Combinational winner finder: highest priority among eligible sources, ties to the lowest id.
module frv_irq_arbiter_prio_tree
  import frv_irq_arbiter_pkg::*;
#(
  parameter int unsigned NSRC   = 15,
  parameter int unsigned PRIO_W = 2
) (
  input  logic [NSRC-1:0]        eligible,
  input  logic [NSRC*PRIO_W-1:0] prio_flat,
  output logic                   valid,
  output logic [IRQ_ID_W-1:0]    id
);

  logic [PRIO_W-1:0] best_prio;

  // Strict compare while scanning upward keeps the lowest id on ties.
  always_comb begin
    best_prio = '0;
    id        = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (eligible[i] && (prio_flat[i*PRIO_W +: PRIO_W] > best_prio)) begin
        best_prio = prio_flat[i*PRIO_W +: PRIO_W];
        id        = IRQ_ID_W'(i + 1);
      end
    end
    valid = (id != '0);
  end

endmodule

// File: rtl/frv_irq_arbiter.sv
// Platform interrupt arbiter: sync, mask, prioritise, then track claim and completion.
// Define FRV_IRQ_EDGE_EN for per-source edge mode with sticky pending bits.
module frv_irq_arbiter
  import frv_irq_arbiter_pkg::*;
#(
  parameter int unsigned NSRC   = 15,
  parameter int unsigned PRIO_W = 2
) (
  input  logic                g_clk,
  input  logic                g_reset,
  input  logic [NSRC-1:0]     irq_src,
  input  logic                cfg_en_we,
  input  logic [NSRC-1:0]     cfg_en_wdata,
  input  logic                cfg_prio_we,
  input  logic [3:0]          cfg_prio_idx,
  input  logic [PRIO_W-1:0]   cfg_prio_wdata,
`ifdef FRV_IRQ_EDGE_EN
  input  logic                cfg_edge_we,
  input  logic [NSRC-1:0]     cfg_edge_wdata,
`endif
  frv_irq_arbiter_if.master   core,
  output arb_state_e          dbg_state
);

  logic [NSRC-1:0]        sync1_q, sync2_q, en_q, line_v, eligible;
  logic [PRIO_W-1:0]      prio_q [NSRC];
  logic [NSRC*PRIO_W-1:0] prio_flat;
  logic                   win_valid, lat_elig, claim;
  logic [IRQ_ID_W-1:0]    win_id, lat_id, cause_q, insvc_q;
  logic                   pend_out_q;
  arb_state_e             state_q;

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      en_q    <= '0;
      for (int i = 0; i < NSRC; i++) prio_q[i] <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
      if (cfg_en_we) en_q <= cfg_en_wdata;
      // Ids outside 1..NSRC never match, so such writes fall away.
      for (int i = 0; i < NSRC; i++)
        if (cfg_prio_we && (cfg_prio_idx == 4'(i + 1))) prio_q[i] <= cfg_prio_wdata;
    end
  end

`ifdef FRV_IRQ_EDGE_EN
  logic [NSRC-1:0] edge_q, sync3_q, pend_q, rise;

  assign rise = sync2_q & ~sync3_q & edge_q;

  // A new edge outranks a same-cycle claim so it is never lost.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      edge_q  <= '0;
      sync3_q <= '0;
      pend_q  <= '0;
    end else begin
      sync3_q <= sync2_q;
      if (cfg_edge_we) edge_q <= cfg_edge_wdata;
      for (int i = 0; i < NSRC; i++) begin
        if (rise[i])                                         pend_q[i] <= 1'b1;
        else if (claim && (lat_id == IRQ_ID_W'(i + 1)))      pend_q[i] <= 1'b0;
      end
    end
  end

  assign line_v = (edge_q & (pend_q | rise)) | (~edge_q & sync2_q);
`else
  assign line_v = sync2_q;
`endif

  always_comb begin
    lat_elig = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      eligible[i] = line_v[i] && en_q[i] && (prio_q[i] != '0) &&
                    (insvc_q != IRQ_ID_W'(i + 1));
      prio_flat[i*PRIO_W +: PRIO_W] = prio_q[i];
      if (lat_id == IRQ_ID_W'(i + 1)) lat_elig = eligible[i];
    end
  end

  frv_irq_arbiter_prio_tree #(.NSRC(NSRC), .PRIO_W(PRIO_W)) u_tree (
    .eligible  (eligible),
    .prio_flat (prio_flat),
    .valid     (win_valid),
    .id        (win_id)
  );

  assign claim = (state_q == ST_REQ) && core.int_trap_ack &&
                 (core.int_trap_cause == {TRAP_INT_EXT_PFX, lat_id});

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q    <= ST_IDLE;
      lat_id     <= '0;
      pend_out_q <= 1'b0;
      cause_q    <= '0;
      insvc_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (win_valid && (insvc_q == '0)) begin
          lat_id  <= win_id;
          state_q <= ST_ARB;
        end
        ST_ARB: begin
          pend_out_q <= 1'b1;
          cause_q    <= lat_id;
          state_q    <= ST_REQ;
        end
        // Latched id is never re-arbitrated; claim is checked ahead of withdraw.
        ST_REQ: if (claim) begin
          insvc_q    <= lat_id;
          pend_out_q <= 1'b0;
          cause_q    <= '0;
          state_q    <= ST_INSVC;
        end else if (!lat_elig) begin
          pend_out_q <= 1'b0;
          cause_q    <= '0;
          state_q    <= ST_IDLE;
        end
        ST_INSVC: if (core.irq_done && (core.irq_done_id == insvc_q)) begin
          insvc_q <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign core.ex_pending = pend_out_q;
  assign core.ex_cause   = cause_q;
  assign core.insvc_id   = insvc_q;
  assign dbg_state       = state_q;

endmodule
